// File: rtl/fpu_compare_seq.sv
// x87 compare sequencer: drives the fp64 magnitude comparator, adds NaN/empty/denormal
// classification, and produces the CC or EFLAGS writeback, the pop count and the exception flags.
module fpu_compare_seq #(
    parameter int CMP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    input  logic        empty_a,
    input  logic        empty_b,
    input  logic        unord_ok,
    input  logic        to_eflags,
    input  logic [1:0]  pop_req,
    input  logic        cw_im,
    input  logic        abort,
    output logic [63:0] cmp_a,
    output logic [63:0] cmp_b,
    input  logic        cmp_lt,
    input  logic        cmp_eq,
    input  logic        cmp_gt,
    output logic        busy,
    output logic        done,
    input  logic        done_ack,
    output logic [3:0]  cc,
    output logic        cc_we,
    output logic        zf,
    output logic        pf,
    output logic        cf,
    output logic        eflags_we,
    output logic [1:0]  pop_cnt,
    output logic        exc_ie,
    output logic        exc_sf,
    output logic        exc_de,
    output logic [1:0]  dbg_state
);

    // Handshake: done stays high in DONE until the cycle done_ack is sampled high;
    // abort wins over done_ack and start in every state.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CMP_LAT);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;

    logic       empty_a_q;
    logic       empty_b_q;
    logic       unord_ok_q;
    logic       to_eflags_q;
    logic [1:0] pop_req_q;
    logic       cw_im_q;

    logic       sf_c;
    logic       nan_c;
    logic       snan_c;
    logic       ie_c;
    logic       de_c;
    logic [3:0] cc_c;
    logic [1:0] pop_sat;
    logic [1:0] pop_c;
    logic       cc_we_c;
    logic       eflags_we_c;

    function automatic logic is_nan(input logic [63:0] v);
        return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
    endfunction

    function automatic logic is_snan(input logic [63:0] v);
        return is_nan(v) && !v[51];
    endfunction

    function automatic logic is_den(input logic [63:0] v);
        return (v[62:52] == 11'h000) && (v[51:0] != 52'd0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = WAIT;
                WAIT:    if (cnt == '0) state_nx = EVAL;
                EVAL:    state_nx = DONE;
                DONE:    if (done_ack) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // Classification works on the latched operands, which are also what the comparator sees.
    always_comb begin
        sf_c   = empty_a_q | empty_b_q;
        nan_c  = !sf_c && (is_nan(cmp_a) || is_nan(cmp_b));
        snan_c = !sf_c && (is_snan(cmp_a) || is_snan(cmp_b));
        ie_c   = sf_c | (nan_c & !unord_ok_q) | snan_c;
        de_c   = !sf_c && !nan_c && (is_den(cmp_a) || is_den(cmp_b));

        if (sf_c || nan_c) begin
            cc_c = 4'b1101;
        end else if (cmp_lt) begin
            cc_c = 4'b0001;
        end else if (cmp_eq) begin
            cc_c = 4'b1000;
        end else if (cmp_gt) begin
            cc_c = 4'b0000;
        end else begin
            cc_c = 4'b1101;
        end

        // FCOMI-class instructions pop at most once.
        pop_sat = (pop_req_q == 2'd3) ? 2'd2 : pop_req_q;
        if (to_eflags_q && (pop_sat == 2'd2)) begin
            pop_sat = 2'd1;
        end

        if (ie_c && !cw_im_q) begin
            cc_we_c     = 1'b0;
            eflags_we_c = 1'b0;
            pop_c       = 2'd0;
        end else begin
            cc_we_c     = !to_eflags_q;
            eflags_we_c = to_eflags_q;
            pop_c       = pop_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            cmp_a       <= '0;
            cmp_b       <= '0;
            empty_a_q   <= 1'b0;
            empty_b_q   <= 1'b0;
            unord_ok_q  <= 1'b0;
            to_eflags_q <= 1'b0;
            pop_req_q   <= 2'd0;
            cw_im_q     <= 1'b0;
            cc          <= 4'd0;
            cc_we       <= 1'b0;
            zf          <= 1'b0;
            pf          <= 1'b0;
            cf          <= 1'b0;
            eflags_we   <= 1'b0;
            pop_cnt     <= 2'd0;
            exc_ie      <= 1'b0;
            exc_sf      <= 1'b0;
            exc_de      <= 1'b0;
        end else if (abort) begin
            cc_we     <= 1'b0;
            eflags_we <= 1'b0;
            exc_ie    <= 1'b0;
            exc_sf    <= 1'b0;
            exc_de    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cmp_a       <= op_a;
                        cmp_b       <= op_b;
                        empty_a_q   <= empty_a;
                        empty_b_q   <= empty_b;
                        unord_ok_q  <= unord_ok;
                        to_eflags_q <= to_eflags;
                        pop_req_q   <= pop_req;
                        cw_im_q     <= cw_im;
                        cnt         <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EVAL: begin
                    cc        <= cc_c;
                    zf        <= cc_c[3];
                    pf        <= cc_c[2];
                    cf        <= cc_c[0];
                    cc_we     <= cc_we_c;
                    eflags_we <= eflags_we_c;
                    pop_cnt   <= pop_c;
                    exc_ie    <= ie_c;
                    exc_sf    <= sf_c;
                    exc_de    <= de_c;
                end
                DONE: begin
                    if (done_ack) begin
                        cc_we     <= 1'b0;
                        eflags_we <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_compare_seq.sv
// Bench for fpu_compare_seq: a CMP_LAT=0 instance for the functional vectors and random runs,
// a CMP_LAT=2 instance for latency, abort-in-WAIT and reset-in-DONE.
module tb_fpu_compare_seq;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          ea;
        bit          eb;
        bit          uo;
        bit          te;
        logic [1:0]  pop;
        bit          im;
        logic [3:0]  e_cc;
        bit          e_ccwe;
        bit          e_efwe;
        logic [1:0]  e_pc;
        bit          e_ie;
        bit          e_sf;
        bit          e_de;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, abort;
    logic [63:0] op_a, op_b;
    logic        empty_a, empty_b, unord_ok, to_eflags, cw_im;
    logic [1:0]  pop_req;

    logic        start0, done_ack0, start2, done_ack2;
    logic [63:0] cmp_a0, cmp_b0, cmp_a2, cmp_b2;
    logic        cmp_lt0, cmp_eq0, cmp_gt0, cmp_lt2, cmp_eq2, cmp_gt2;
    logic        busy0, done0, cc_we0, zf0, pf0, cf0, eflags_we0, exc_ie0, exc_sf0, exc_de0;
    logic        busy2, done2, cc_we2, zf2, pf2, cf2, eflags_we2, exc_ie2, exc_sf2, exc_de2;
    logic [3:0]  cc0, cc2;
    logic [1:0]  pop_cnt0, pop_cnt2, dbg_state0, dbg_state2;
    logic [2:0]  pipe1, pipe2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Comparator model: real-valued compare with denormals flushed to zero.
    function automatic real to_val(input logic [63:0] v);
        if (v[62:52] == 11'h000) return 0.0;
        return $bitstoreal(v);
    endfunction

    function automatic logic [2:0] cmp3(input logic [63:0] a, input logic [63:0] b);
        real ra = to_val(a);
        real rb = to_val(b);
        return {ra < rb, ra == rb, ra > rb};
    endfunction

    assign {cmp_lt0, cmp_eq0, cmp_gt0} = cmp3(cmp_a0, cmp_b0);

    always_ff @(posedge clk) begin
        pipe1 <= cmp3(cmp_a2, cmp_b2);
        pipe2 <= pipe1;
    end
    assign {cmp_lt2, cmp_eq2, cmp_gt2} = pipe2;

    fpu_compare_seq #(.CMP_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op_a(op_a), .op_b(op_b),
        .empty_a(empty_a), .empty_b(empty_b), .unord_ok(unord_ok), .to_eflags(to_eflags),
        .pop_req(pop_req), .cw_im(cw_im), .abort(abort), .cmp_a(cmp_a0), .cmp_b(cmp_b0),
        .cmp_lt(cmp_lt0), .cmp_eq(cmp_eq0), .cmp_gt(cmp_gt0), .busy(busy0), .done(done0),
        .done_ack(done_ack0), .cc(cc0), .cc_we(cc_we0), .zf(zf0), .pf(pf0), .cf(cf0),
        .eflags_we(eflags_we0), .pop_cnt(pop_cnt0), .exc_ie(exc_ie0), .exc_sf(exc_sf0),
        .exc_de(exc_de0), .dbg_state(dbg_state0)
    );

    fpu_compare_seq #(.CMP_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op_a(op_a), .op_b(op_b),
        .empty_a(empty_a), .empty_b(empty_b), .unord_ok(unord_ok), .to_eflags(to_eflags),
        .pop_req(pop_req), .cw_im(cw_im), .abort(abort), .cmp_a(cmp_a2), .cmp_b(cmp_b2),
        .cmp_lt(cmp_lt2), .cmp_eq(cmp_eq2), .cmp_gt(cmp_gt2), .busy(busy2), .done(done2),
        .done_ack(done_ack2), .cc(cc2), .cc_we(cc_we2), .zf(zf2), .pf(pf2), .cf(cf2),
        .eflags_we(eflags_we2), .pop_cnt(pop_cnt2), .exc_ie(exc_ie2), .exc_sf(exc_sf2),
        .exc_de(exc_de2), .dbg_state(dbg_state2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input bit ea,
                                input bit eb, input bit uo, input bit te, input logic [1:0] pop,
                                input bit im, input logic [3:0] e_cc, input bit e_ccwe,
                                input bit e_efwe, input logic [1:0] e_pc, input bit e_ie,
                                input bit e_sf, input bit e_de);
        vec_t v;
        v.a = a; v.b = b; v.ea = ea; v.eb = eb; v.uo = uo; v.te = te; v.pop = pop; v.im = im;
        v.e_cc = e_cc; v.e_ccwe = e_ccwe; v.e_efwe = e_efwe; v.e_pc = e_pc;
        v.e_ie = e_ie; v.e_sf = e_sf; v.e_de = e_de;
        return v;
    endfunction

    function automatic bit f_nan(input logic [63:0] v);
        return (v[62:52] == 11'h7FF) && (v[51:0] != 0);
    endfunction

    // Reference model written directly from the instruction-level rules.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r = v;
        bit sf = v.ea | v.eb;
        bit nan = !sf && (f_nan(v.a) || f_nan(v.b));
        bit snan = !sf && ((f_nan(v.a) && !v.a[51]) || (f_nan(v.b) && !v.b[51]));
        bit den = (v.a[62:52] == 0 && v.a[51:0] != 0) || (v.b[62:52] == 0 && v.b[51:0] != 0);
        int pops = (v.pop == 3) ? 2 : int'(v.pop);
        real ra = to_val(v.a);
        real rb = to_val(v.b);
        if (v.te && pops == 2) pops = 1;
        r.e_sf = sf;
        r.e_ie = sf || (nan && !v.uo) || snan;
        r.e_de = den && !sf && !nan;
        if (sf || nan)    r.e_cc = 4'b1101;
        else if (ra < rb) r.e_cc = 4'b0001;
        else if (ra > rb) r.e_cc = 4'b0000;
        else              r.e_cc = 4'b1000;
        if (r.e_ie && !v.im) begin
            r.e_ccwe = 0; r.e_efwe = 0; r.e_pc = 0;
        end else begin
            r.e_ccwe = !v.te; r.e_efwe = v.te; r.e_pc = 2'(pops);
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        op_a = v.a; op_b = v.b; empty_a = v.ea; empty_b = v.eb;
        unord_ok = v.uo; to_eflags = v.te; pop_req = v.pop; cw_im = v.im;
    endtask

    task automatic issue0(input vec_t v, output int lat);
        @(posedge clk); #1;
        drive(v);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        lat = 1;
        while (!done0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done0_rise", done0, 1'b1);
    endtask

    task automatic check_res0(input string tag, input vec_t v);
        chk({tag, "_cc_we"}, cc_we0, v.e_ccwe);
        chk({tag, "_eflags_we"}, eflags_we0, v.e_efwe);
        chk({tag, "_pop_cnt"}, pop_cnt0, v.e_pc);
        chk({tag, "_exc_ie"}, exc_ie0, v.e_ie);
        chk({tag, "_exc_sf"}, exc_sf0, v.e_sf);
        chk({tag, "_exc_de"}, exc_de0, v.e_de);
        if (v.e_ccwe) chk({tag, "_cc"}, cc0, v.e_cc);
        if (v.e_efwe) chk({tag, "_zpc"}, {zf0, pf0, cf0}, {v.e_cc[3], v.e_cc[2], v.e_cc[0]});
    endtask

    task automatic ack0();
        done_ack0 = 1'b1;
        @(posedge clk); #1;
        done_ack0 = 1'b0;
        chk("ack_done", done0, 1'b0);
        chk("ack_busy", busy0, 1'b0);
        chk("ack_we", {cc_we0, eflags_we0}, 2'b00);
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: return {r[63], 11'($urandom_range(1, 2046)), r[51:0]};
            1: return {r[63], 63'd0};
            2: return {r[63], 11'h000, r[51:0] | 52'd1};
            3: return {r[63], 11'h7FF, 52'd0};
            4: return {r[63], 11'h7FF, 1'b1, r[50:0]};
            5: return {r[63], 11'h7FF, 1'b0, r[50:0] | 51'd1};
            6: return 64'h3FF0000000000000;
            default: return {r[63], 11'h400, 52'd0};
        endcase
    endfunction

    vec_t tbl[14];
    vec_t v;
    int lat;
    bit seen;

    initial begin
        rst = 1'b1; abort = 1'b0; start0 = 1'b0; start2 = 1'b0;
        done_ack0 = 1'b0; done_ack2 = 1'b0;
        op_a = '0; op_b = '0; empty_a = 0; empty_b = 0; unord_ok = 0; to_eflags = 0;
        pop_req = 0; cw_im = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs0", {done0, busy0, cc0, cc_we0, zf0, pf0, cf0, eflags_we0, pop_cnt0,
                          exc_ie0, exc_sf0, exc_de0, dbg_state0}, '0);
        chk("rst_cmp0", cmp_a0 | cmp_b0, '0);
        chk("rst_outs2", {done2, busy2, cc2, cc_we2, eflags_we2, pop_cnt2, exc_ie2}, '0);
        rst = 1'b0;

        //            a                      b                      ea eb uo te pop im cc      ccwe efwe pc ie sf de
        tbl[0]  = mk(64'h3FF0000000000000, 64'h4000000000000000, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(64'h0000000000000000, 64'h8000000000000000, 0, 0, 0, 0, 2, 1, 4'b1000, 1, 0, 2, 0, 0, 0);
        tbl[2]  = mk(64'h0000000000000001, 64'h8000000000000000, 0, 0, 0, 0, 2, 1, 4'b1000, 1, 0, 2, 0, 0, 1);
        tbl[3]  = mk(64'h3FF0000000000000, 64'h7FF8000000000000, 0, 0, 1, 0, 0, 1, 4'b1101, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(64'h3FF0000000000000, 64'h7FF8000000000000, 0, 0, 0, 0, 0, 1, 4'b1101, 1, 0, 0, 1, 0, 0);
        tbl[5]  = mk(64'h3FF0000000000000, 64'h7FF8000000000000, 0, 0, 0, 0, 1, 0, 4'b1101, 0, 0, 0, 1, 0, 0);
        tbl[6]  = mk(64'h3FF0000000000000, 64'h7FF0000000000001, 0, 0, 1, 1, 2, 1, 4'b1101, 0, 1, 1, 1, 0, 0);
        tbl[7]  = mk(64'h4000000000000000, 64'h0000000000000000, 0, 1, 0, 0, 0, 1, 4'b1101, 1, 0, 0, 1, 1, 0);
        tbl[8]  = mk(64'h4000000000000000, 64'h3FF0000000000000, 0, 0, 0, 0, 1, 1, 4'b0000, 1, 0, 1, 0, 0, 0);
        tbl[9]  = mk(64'hBFF0000000000000, 64'h0000000000000000, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(64'h4000000000000000, 64'h4000000000000000, 0, 0, 0, 0, 3, 0, 4'b1000, 1, 0, 2, 0, 0, 0);
        tbl[11] = mk(64'h7FF4000000000000, 64'h3FF0000000000000, 0, 0, 1, 0, 1, 0, 4'b1101, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(64'h0000000000000001, 64'h7FF8000000000000, 0, 0, 1, 0, 0, 0, 4'b1101, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(64'h3FF0000000000000, 64'h7FF8000000000000, 1, 0, 1, 0, 2, 0, 4'b1101, 0, 0, 0, 1, 1, 0);

        // First op: latency T+3, then done and results held through 5 idle-ack cycles.
        issue0(tbl[0], lat);
        chk("lat0", lat, 3);
        check_res0("v0", tbl[0]);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_done", done0, 1'b1);
            chk("hold_res", {cc0, cc_we0, pop_cnt0, exc_ie0}, {4'b0001, 1'b1, 2'd0, 1'b0});
        end
        ack0();

        for (int i = 1; i < 14; i++) begin
            issue0(tbl[i], lat);
            chk($sformatf("lat_v%0d", i), lat, 3);
            check_res0($sformatf("v%0d", i), tbl[i]);
            ack0();
        end

        // start pulsed while busy must not replace the latched operands.
        @(posedge clk); #1;
        drive(tbl[7]);
        start0 = 1'b1;
        @(posedge clk); #1;
        drive(tbl[0]);
        @(posedge clk); #1;
        start0 = 1'b0;
        lat = 2;
        while (!done0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_ign_lat", lat, 3);
        chk("busy_ign_cmp_a", cmp_a0, 64'h4000000000000000);
        check_res0("busy_ign", tbl[7]);
        ack0();
        @(posedge clk); #1;
        chk("busy_ign_idle", busy0, 1'b0);

        // abort in DONE clears done, write enables and exceptions.
        issue0(tbl[7], lat);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done_clr", {done0, busy0, cc_we0, eflags_we0, exc_ie0, exc_sf0, exc_de0}, '0);

        // Randomized operations against the reference model, with random ack delay.
        for (int i = 0; i < 150; i++) begin
            v.a = rand_op();
            v.b = ($urandom_range(0, 5) == 0) ? v.a : rand_op();
            v.ea = ($urandom_range(0, 9) == 0);
            v.eb = ($urandom_range(0, 9) == 0);
            v.uo = $urandom_range(0, 1);
            v.te = $urandom_range(0, 1);
            v.pop = 2'($urandom_range(0, 3));
            v.im = $urandom_range(0, 1);
            v = ref_model(v);
            issue0(v, lat);
            chk("rnd_lat", lat, 3);
            check_res0($sformatf("rnd%0d", i), v);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            chk("rnd_hold", done0, 1'b1);
            ack0();
        end

        // CMP_LAT=2: abort in WAIT, then normal latency, then reset in DONE.
        @(posedge clk); #1;
        drive(tbl[0]);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("l2_abort_busy", busy2, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done2) seen = 1;
            @(posedge clk); #1;
        end
        chk("l2_abort_no_done", seen, 1'b0);

        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("l2_lat", lat, 5);
        chk("l2_res", {cc2, cc_we2, eflags_we2, pop_cnt2, exc_ie2}, {4'b0001, 1'b1, 1'b0, 2'd0, 1'b0});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("l2_rst_outs", {done2, busy2, cc2, cc_we2, zf2, pf2, cf2, eflags_we2, pop_cnt2,
                            exc_ie2, exc_sf2, exc_de2, dbg_state2}, '0);
        chk("l2_rst_cmp", cmp_a2 | cmp_b2, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_compare_seq.md
Name: fpu_compare_seq

Overview:
Sequencer for the x87 compare instruction family: FCOM/FCOMP/FCOMPP, FUCOM/FUCOMP/FUCOMPP, FCOMI/FCOMIP/FUCOMI/FUCOMIP. It sits directly downstream of the fp64 magnitude comparator. It drives that comparator's operands, samples its lt/eq/gt result, and adds NaN, empty-register and denormal classification, which the comparator does not do. It produces the condition-code or EFLAGS writeback, the stack pop count and the exception flags, and hands the result to the FPU control path over a done/ack handshake.

Parameters:
CMP_LAT, 0, number of register stages between cmp_a/cmp_b and cmp_lt/cmp_eq/cmp_gt (0 = purely combinational comparator).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request pulse; accepted only in IDLE
op_a  in  64  ST(0) as fp64
op_b  in  64  source operand as fp64
empty_a  in  1  ST(0) tag empty
empty_b  in  1  source tag empty (0 for memory operands)
unord_ok  in  1  1 = FUCOM class (QNaN quiet)
to_eflags  in  1  1 = FCOMI class (write ZF/PF/CF, not C3..C0)
pop_req  in  2  number of pops requested (0, 1, 2)
cw_im  in  1  invalid-operation mask bit from the control word
abort  in  1  synchronous kill from the pipeline flush
cmp_a  out  64  comparator operand a (registered)
cmp_b  out  64  comparator operand b (registered)
cmp_lt  in  1  comparator result
cmp_eq  in  1  comparator result
cmp_gt  in  1  comparator result
busy  out  1  state != IDLE
done  out  1  result valid; held until done_ack
done_ack  in  1  consumer accepts result
cc  out  4  {C3,C2,C1,C0}
cc_we  out  1  write cc into the status word
zf  out  1  EFLAGS result
pf  out  1  EFLAGS result
cf  out  1  EFLAGS result
eflags_we  out  1  write zf/pf/cf
pop_cnt  out  2  pops to perform
exc_ie  out  1  invalid operation
exc_sf  out  1  stack fault
exc_de  out  1  denormal operand

Behaviour:
- Reset: state IDLE; every output 0, including cmp_a and cmp_b.
- FSM states: IDLE, WAIT, EVAL, DONE.
- IDLE + start:
  - Register op_a/op_b into cmp_a/cmp_b; register empty_a/b, unord_ok, to_eflags, pop_req, cw_im.
  - Go to WAIT and load the latency counter with CMP_LAT.
  - start outside IDLE is ignored.
- WAIT: counter decrements each cycle; at 0 go to EVAL. With CMP_LAT=0, WAIT lasts exactly one cycle.
- EVAL (one cycle):
  - Sample cmp_lt/eq/gt and compute all outputs into registers.
  - Go to DONE.
- Latency: done rises in cycle T+3+CMP_LAT, where start is in cycle T.
- DONE:
  - done=1 and all result outputs are held stable.
  - done_ack moves to IDLE next cycle, with done and the write enables cleared.
  - In IDLE, result values are don't-care but the write enables are 0.
- abort: in any state, go to IDLE next cycle; done, cc_we, eflags_we and exc_* are cleared. abort has priority over done_ack and start.
- Classification (a NaN is exp=7FF and frac!=0; a QNaN has frac[51]=1; a denormal is exp=0 and frac!=0):
  - sf = empty_a | empty_b.
  - nan = either operand NaN, ignored when sf.
  - snan = either operand SNaN, ignored when sf.
  - ie = sf | (nan & !unord_ok) | snan.
  - de = either operand denormal & !sf & !nan.
- Result select:
  - Unordered when sf | nan.
  - Otherwise exactly one of lt/eq/gt is taken from the comparator. Denormals compare as zero; ±0 compare equal.
- Condition-code mapping:
  - cc encodings: gt = 0000, lt = 0001, eq = 1000, unordered = 1101.
  - C1 is always 0.
  - For to_eflags, ZF/PF/CF use the same pattern as C3/C2/C0.
- Write enables:
  - If ie & !cw_im: cc_we=0, eflags_we=0, pop_cnt=0, exc_ie=1.
  - Otherwise cc_we = !to_eflags, eflags_we = to_eflags, pop_cnt = pop_req.
  - to_eflags with pop_req=2 is clamped to pop_cnt=1.
  - pop_req=3 is treated as 2.
- exc_ie, exc_sf and exc_de are reported regardless of masking. Masking of sf and de is the consumer's job.

Test Plan:
- CMP_LAT=0, FCOM, op_a=3FF0000000000000 (1.0), op_b=4000000000000000 (2.0) -> done in cycle T+3; cc=0001; cc_we=1; pop_cnt=0; no exceptions. Hold done_ack low 5 cycles -> outputs stable; ack -> IDLE next cycle.
- FCOMPP, op_a=0000000000000000, op_b=8000000000000000 (-0) -> cc=1000, pop_cnt=2. Repeat with op_a=0000000000000001 (denormal) -> cc=1000, exc_de=1.
- FUCOM with op_b=7FF8000000000000 (QNaN) -> cc=1101, exc_ie=0. FCOM with the same operands and cw_im=1 -> cc=1101, exc_ie=1, cc_we=1. FCOM with cw_im=0 -> cc_we=0, pop_cnt=0, exc_ie=1.
- FUCOMIP with op_b=7FF0000000000001 (SNaN), cw_im=1, pop_req=2 -> zf=pf=cf=1, eflags_we=1, cc_we=0, pop_cnt=1, exc_ie=1.
- empty_b=1 with op_a=4000000000000000 -> exc_sf=1, exc_ie=1, cc=1101. Also pulse start while busy -> ignored; operands latched at the first start remain.
- CMP_LAT=2: abort asserted in WAIT -> busy=0 next cycle, done never rises. Assert rst in DONE -> all outputs 0 the next cycle.
